// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding selects and load-use stall control
// for the pipelined MIPS core.
// Optional feature macro: FWD_HAZARD_STATS_EN adds the stall_cycles and
// hazard_cnt statistics outputs.
module fwd_hazard_unit #(
  parameter int REG_W    = 5,
  parameter int NSRC     = 2,
  parameter int NSTAGE   = 2,
  parameter int LOAD_LAT = 1,
  localparam int SW      = $clog2(NSTAGE + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSRC*REG_W-1:0]   ex_src,
  input  logic [NSRC*REG_W-1:0]   id_src,
  input  logic [NSRC-1:0]         id_src_used,
  input  logic                    id_valid,
  input  logic                    ex_regwrite,
  input  logic                    ex_is_load,
  input  logic [REG_W-1:0]        ex_wr,
  input  logic [NSTAGE-1:0]       st_regwrite,
  input  logic [NSTAGE*REG_W-1:0] st_wr,
  input  logic                    flush,
  output logic [NSRC*SW-1:0]      fwd_sel,
  output logic                    stall,
  output logic                    bubble,
  output logic                    pc_we,
  output logic                    ifid_we
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [15:0]             hazard_cnt
`endif
);

  typedef enum logic {IDLE, STALL} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       src_match;
  logic       ld_hit;

  // Per-operand forwarding: scan furthest to nearest so the nearest match wins.
  always_comb begin
    fwd_sel = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      for (int unsigned k = NSTAGE; k >= 1; k--) begin
        if (st_regwrite[k-1] &&
            (st_wr[(k-1)*REG_W +: REG_W] != '0) &&
            (st_wr[(k-1)*REG_W +: REG_W] == ex_src[i*REG_W +: REG_W]))
          fwd_sel[i*SW +: SW] = SW'(k);
      end
    end
  end

  // Load-use detection: a used ID operand reads the register the EX load writes.
  always_comb begin
    src_match = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (id_src_used[i] && (id_src[i*REG_W +: REG_W] == ex_wr))
        src_match = 1'b1;
    end
    ld_hit = id_valid & ex_regwrite & ex_is_load & (ex_wr != '0) & src_match;
  end

  // Stall outputs: IDLE stalls on a fresh hazard, STALL holds until done; flush overrides.
  always_comb begin
    if (state == IDLE) stall = ld_hit & ~flush;
    else               stall = ~flush;
    bubble  = stall | flush;
    pc_we   = ~stall;
    ifid_we = ~stall;
  end

  // Stall sequencer: the IDLE detection cycle is the first stall cycle, so
  // STALL only covers the remaining LOAD_LAT-1 cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_hit && !flush && (LOAD_LAT > 1)) begin
            state <= STALL;
            cnt   <= LAT_M1;
          end
        end
        STALL: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  // Saturating statistics: total stalled cycles and number of detected hazards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      hazard_cnt   <= '0;
    end else begin
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if ((state == IDLE) && ld_hit && !flush && (hazard_cnt != '1))
        hazard_cnt <= hazard_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scoreboard bench for fwd_hazard_unit: LOAD_LAT=1 and LOAD_LAT=3
// instances (plus LOAD_LAT=2 with statistics when FWD_HAZARD_STATS_EN is set)
// share one set of stimulus.
module tb_fwd_hazard_unit;

  localparam int REG_W = 5;
  localparam int NSRC  = 2;
  localparam int NST   = 2;
  localparam int SW    = 2;

  localparam int S_FS0 = 0, S_FS1 = 1, S_ST1 = 2, S_ST3 = 3, S_PC3 = 4;
  localparam int S_BB3 = 5, S_IF3 = 6, S_PC1 = 7, S_HC = 8, S_SC = 9, S_ST2 = 10;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NSRC*REG_W-1:0]   ex_src;
  logic [NSRC*REG_W-1:0]   id_src;
  logic [NSRC-1:0]         id_src_used;
  logic                    id_valid;
  logic                    ex_regwrite;
  logic                    ex_is_load;
  logic [REG_W-1:0]        ex_wr;
  logic [NST-1:0]          st_regwrite;
  logic [NST*REG_W-1:0]    st_wr;
  logic                    flush;

  logic [NSRC*SW-1:0] fwd1, fwd3, fwd2;
  logic stall1, bubble1, pc_we1, ifid_we1;
  logic stall3, bubble3, pc_we3, ifid_we3;
  logic stall2, bubble2, pc_we2, ifid_we2;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] hazard_cnt;
`endif

  int vectors = 0;
  int misses  = 0;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_W(REG_W), .NSRC(NSRC), .NSTAGE(NST), .LOAD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .ex_src(ex_src), .id_src(id_src), .id_src_used(id_src_used),
    .id_valid(id_valid), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .ex_wr(ex_wr),
    .st_regwrite(st_regwrite), .st_wr(st_wr), .flush(flush), .fwd_sel(fwd1),
    .stall(stall1), .bubble(bubble1), .pc_we(pc_we1), .ifid_we(ifid_we1));

  fwd_hazard_unit #(.REG_W(REG_W), .NSRC(NSRC), .NSTAGE(NST), .LOAD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .ex_src(ex_src), .id_src(id_src), .id_src_used(id_src_used),
    .id_valid(id_valid), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .ex_wr(ex_wr),
    .st_regwrite(st_regwrite), .st_wr(st_wr), .flush(flush), .fwd_sel(fwd3),
    .stall(stall3), .bubble(bubble3), .pc_we(pc_we3), .ifid_we(ifid_we3));

`ifdef FWD_HAZARD_STATS_EN
  fwd_hazard_unit #(.REG_W(REG_W), .NSRC(NSRC), .NSTAGE(NST), .LOAD_LAT(2)) u2 (
    .clk(clk), .rst(rst), .ex_src(ex_src), .id_src(id_src), .id_src_used(id_src_used),
    .id_valid(id_valid), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .ex_wr(ex_wr),
    .st_regwrite(st_regwrite), .st_wr(st_wr), .flush(flush), .fwd_sel(fwd2),
    .stall(stall2), .bubble(bubble2), .pc_we(pc_we2), .ifid_we(ifid_we2),
    .stall_cycles(stall_cycles), .hazard_cnt(hazard_cnt));
`else
  assign fwd2 = '0;
  assign {stall2, bubble2, pc_we2, ifid_we2} = '0;
`endif

  function automatic logic [31:0] obs(int sig);
    case (sig)
      S_FS0: obs = 32'(fwd1[SW-1:0]);
      S_FS1: obs = 32'(fwd1[2*SW-1:SW]);
      S_ST1: obs = 32'(stall1);
      S_ST3: obs = 32'(stall3);
      S_PC3: obs = 32'(pc_we3);
      S_BB3: obs = 32'(bubble3);
      S_IF3: obs = 32'(ifid_we3);
      S_PC1: obs = 32'(pc_we1);
      S_ST2: obs = 32'(stall2);
`ifdef FWD_HAZARD_STATS_EN
      S_HC:  obs = 32'(hazard_cnt);
      S_SC:  obs = stall_cycles;
`endif
      default: obs = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(string tag, int sig, logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [31:0] o;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sig);
      vectors++;
      assert (o === e.val) else begin
        misses++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic hazard(input logic on);
    id_valid    = on;
    ex_regwrite = on;
    ex_is_load  = on;
    ex_wr       = on ? 5'd7 : 5'd0;
    id_src      = {5'd3, 5'd7};
    id_src_used = 2'b01;
  endtask

  initial begin
    rst = 1'b0;
    ex_src = '0; id_src = '0; id_src_used = '0; id_valid = 1'b0;
    ex_regwrite = 1'b0; ex_is_load = 1'b0; ex_wr = '0;
    st_regwrite = '0; st_wr = '0; flush = 1'b0;

    // reset state
    @(negedge clk);
    expect_val("rst_stall3", S_ST3, 0);
    expect_val("rst_pc_we3", S_PC3, 1);
    expect_val("rst_ifid3", S_IF3, 1);
    expect_val("rst_bubble3", S_BB3, 0);
    check();
    @(negedge clk); flush = 1'b1;
    expect_val("rst_bubble_flush", S_BB3, 1);
    expect_val("rst_stall1", S_ST1, 0);
    check();
    @(negedge clk); flush = 1'b0; rst = 1'b1;

    // forwarding priority
    ex_src = {5'd0, 5'd5}; st_wr = {5'd5, 5'd5}; st_regwrite = 2'b11;
    expect_val("fwd_both", S_FS0, 1);
    check();
    @(negedge clk); st_regwrite = 2'b10;
    expect_val("fwd_far", S_FS0, 2);
    check();
    @(negedge clk); st_wr = {5'd9, 5'd0}; st_regwrite = 2'b01;
    expect_val("fwd_zero_idx", S_FS1, 0);
    expect_val("fwd_nomatch", S_FS0, 0);
    check();
    @(negedge clk); ex_src = {5'd9, 5'd5}; st_regwrite = 2'b11;
    expect_val("fwd_op1_far", S_FS1, 2);
    expect_val("fwd_op0_none", S_FS0, 0);
    check();
    @(negedge clk); st_regwrite = 2'b00;

    // load-use hazard: LOAD_LAT=1 and LOAD_LAT=3
    hazard(1'b1);
    expect_val("lu_c0_stall1", S_ST1, 1);
    expect_val("lu_c0_pc1", S_PC1, 0);
    expect_val("lu_c0_stall3", S_ST3, 1);
    expect_val("lu_c0_pc3", S_PC3, 0);
    expect_val("lu_c0_bubble3", S_BB3, 1);
    check();
    @(negedge clk); hazard(1'b0);
    expect_val("lu_c1_stall1", S_ST1, 0);
    expect_val("lu_c1_stall3", S_ST3, 1);
    expect_val("lu_c1_ifid3", S_IF3, 0);
    check();
    @(negedge clk);
    expect_val("lu_c2_stall3", S_ST3, 1);
    expect_val("lu_c2_pc3", S_PC3, 0);
    check();
    // back-to-back hazard right after STALL returns to IDLE
    @(negedge clk); hazard(1'b1);
    expect_val("b2b_stall3", S_ST3, 1);
    check();
    @(negedge clk); hazard(1'b0); flush = 1'b1;
    expect_val("flush_stall3", S_ST3, 0);
    expect_val("flush_bubble3", S_BB3, 1);
    expect_val("flush_pc3", S_PC3, 1);
    check();
    @(negedge clk); flush = 1'b0;
    expect_val("post_flush_idle", S_ST3, 0);
    check();

    // unused operand: no hazard
    @(negedge clk); hazard(1'b1); id_src_used = 2'b00;
    expect_val("unused_stall1", S_ST1, 0);
    expect_val("unused_stall3", S_ST3, 0);
    check();
    // simultaneous flush and hazard
    @(negedge clk); hazard(1'b1); flush = 1'b1;
    expect_val("fl_hit_stall3", S_ST3, 0);
    expect_val("fl_hit_bubble3", S_BB3, 1);
    check();
    @(negedge clk); hazard(1'b0); flush = 1'b0;
    expect_val("fl_hit_idle", S_ST3, 0);
    check();

    // asynchronous reset mid-stall
    @(negedge clk); hazard(1'b1);
    expect_val("rs_c0_stall3", S_ST3, 1);
    check();
    @(negedge clk); hazard(1'b0);
    expect_val("rs_c1_stall3", S_ST3, 1);
    check();
    rst = 1'b0;
    #1;
    expect_val("rs_async_stall3", S_ST3, 0);
    expect_val("rs_async_pc3", S_PC3, 1);
    check();
    @(negedge clk); rst = 1'b1;
    expect_val("rs_after_stall3", S_ST3, 0);
    check();

`ifdef FWD_HAZARD_STATS_EN
    expect_val("stats_hc0", S_HC, 0);
    expect_val("stats_sc0", S_SC, 0);
    check();
    for (int h = 0; h < 2; h++) begin
      @(negedge clk); hazard(1'b1);
      expect_val("st2_c0", S_ST2, 1);
      check();
      @(negedge clk); hazard(1'b0);
      expect_val("st2_c1", S_ST2, 1);
      check();
      @(negedge clk);
      expect_val("st2_c2", S_ST2, 0);
      check();
    end
    @(negedge clk);
    expect_val("stats_hc", S_HC, 2);
    expect_val("stats_sc", S_SC, 4);
    check();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
